// File: rtl/axin_merge.sv
// Round-robin merge of NIN packet streams into one; 1-cycle grant, 1-cycle beat latency.
// Upstream sees S_READY only for the granted port while the output register can accept.
module axin_merge #(
  parameter int NIN          = 4,
  parameter int DW           = 64,
  parameter int WBITS        = $clog2(DW/8),
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [NIN-1:0]          i_cfg_active,
  input  logic [NIN-1:0]          S_VALID,
  output logic [NIN-1:0]          S_READY,
  input  logic [NIN*DW-1:0]       S_DATA,
  input  logic [NIN*WBITS-1:0]    S_BYTES,
  input  logic [NIN-1:0]          S_LAST,
  input  logic [NIN-1:0]          S_ABORT,
  output logic                    M_VALID,
  input  logic                    M_READY,
  output logic [DW-1:0]           M_DATA,
  output logic [WBITS-1:0]        M_BYTES,
  output logic                    M_LAST,
  output logic                    M_ABORT,
  output logic [$clog2(NIN)-1:0]  M_SRC
);

  localparam int SW = $clog2(NIN);
  localparam logic [SW:0] NIN_W = (SW+1)'(NIN);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t        state, state_d;
  logic [SW-1:0] gnt, gnt_d;
  logic          fwd_any, fwd_any_d;
  logic [NIN-1:0] cand;
  logic          g_vld, g_last, g_abort, g_rdy;
  logic          fwd_beat, set_abort;
  logic          m_valid_d, m_abort_d;
  logic          found;
  logic [SW:0]   sum;
  logic [SW-1:0] idx_b;

  assign cand    = S_VALID & i_cfg_active & ~S_ABORT;
  assign g_vld   = S_VALID[gnt];
  assign g_last  = S_LAST[gnt];
  assign g_abort = S_ABORT[gnt];
  // A pending M_ABORT blocks new beats until it has been delivered.
  assign g_rdy   = (state == GRANTED) && i_cfg_active[gnt] && !M_ABORT && (!M_VALID || M_READY);

  always_comb begin
    S_READY      = '0;
    S_READY[gnt] = g_rdy;
  end

  always_comb begin
    state_d   = state;
    gnt_d     = gnt;
    fwd_any_d = fwd_any;
    fwd_beat  = 1'b0;
    set_abort = 1'b0;
    found     = 1'b0;
    sum       = '0;
    idx_b     = '0;
    case (state)
      IDLE: begin
        for (int i = 1; i <= NIN; i++) begin
          sum = {1'b0, gnt} + (SW+1)'(i);
          if (sum >= NIN_W) sum = sum - NIN_W;
          idx_b = sum[SW-1:0];
          if (!found && cand[idx_b]) begin
            found = 1'b1;
            gnt_d = idx_b;
          end
        end
        if (found) begin
          state_d   = GRANTED;
          fwd_any_d = 1'b0;
        end
      end
      GRANTED: begin
        // An accepted LAST beat wins over a same-cycle abort.
        if (g_vld && g_rdy && g_last) begin
          fwd_beat = 1'b1;
          state_d  = IDLE;
        end else if (!i_cfg_active[gnt] || (g_abort && (!g_vld || g_rdy))) begin
          state_d   = IDLE;
          set_abort = fwd_any;
        end else if (g_vld && g_rdy) begin
          fwd_beat  = 1'b1;
          fwd_any_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_valid_d = M_VALID;
    m_abort_d = M_ABORT;
    if (M_ABORT && (!M_VALID || M_READY)) begin
      m_valid_d = 1'b0;
      m_abort_d = 1'b0;
    end else if (set_abort) begin
      m_abort_d = 1'b1;
      if (M_READY) m_valid_d = 1'b0;
    end else if (!M_VALID || M_READY) begin
      m_valid_d = fwd_beat;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      gnt     <= SW'(NIN-1);
      fwd_any <= 1'b0;
    end else begin
      state   <= state_d;
      gnt     <= gnt_d;
      fwd_any <= fwd_any_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      M_VALID <= 1'b0;
      M_ABORT <= 1'b0;
      M_DATA  <= '0;
      M_BYTES <= '0;
      M_LAST  <= 1'b0;
      M_SRC   <= '0;
    end else begin
      M_VALID <= m_valid_d;
      M_ABORT <= m_abort_d;
      if (fwd_beat) begin
        M_DATA  <= S_DATA[int'(gnt)*DW +: DW];
        M_BYTES <= S_BYTES[int'(gnt)*WBITS +: WBITS];
        M_LAST  <= g_last;
        M_SRC   <= gnt;
      end else if (OPT_LOWPOWER && !m_valid_d) begin
        M_DATA  <= '0;
        M_BYTES <= '0;
        M_LAST  <= 1'b0;
        M_SRC   <= '0;
      end
    end
  end

endmodule
